// File: rtl/serial_sub_8bit_if.sv
// Request/response bundle for the bit-serial subtractor.
// The master drives the operands; the slave returns status and the result.
interface serial_sub_8bit_if #(
  parameter int unsigned BIT_WIDTH = 8
);
  logic                 start;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 borrow_in;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] diff;
  logic                 borrow_out;
  logic                 overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_sub_8bit.sv
// Bit-serial subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Results are published only when the last bit has been processed.
module serial_sub_8bit #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  serial_sub_8bit_if.slave bus
);

  localparam int unsigned CNT_W    = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam int unsigned LAST_BIT = BIT_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 load_c;
  logic                 step_c;
  logic                 finish_c;

  logic [BIT_WIDTH-1:0] a_sr;
  logic [BIT_WIDTH-1:0] b_sr;
  logic [BIT_WIDTH-1:0] res_sr;
  logic                 br_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 d_bit_c;
  logic                 br_next_c;
  logic                 ovf_c;

  // Next-state and control strobes; start is only honoured outside CALC.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(LAST_BIT)) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_c  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One full-subtractor slice; on the final step a_sr[0]/b_sr[0] are the MSBs.
  always_comb begin
    d_bit_c   = a_sr[0] ^ b_sr[0] ^ br_q;
    br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br_q);
    ovf_c     = (a_sr[0] != b_sr[0]) & (d_bit_c != a_sr[0]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr           <= '0;
      b_sr           <= '0;
      res_sr         <= '0;
      br_q           <= 1'b0;
      cnt_q          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.diff       <= '0;
      bus.borrow_out <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.busy <= (state_d == CALC);
      bus.done <= (state_d == DONE);
      if (load_c) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        br_q   <= bus.borrow_in;
        cnt_q  <= '0;
        res_sr <= '0;
      end else if (step_c) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br_q   <= br_next_c;
        cnt_q  <= cnt_q + CNT_W'(1);
        res_sr <= {d_bit_c, res_sr[BIT_WIDTH-1:1]};
      end
      // Visible results change only here, so partial sums never leak out.
      if (finish_c) begin
        bus.diff       <= {d_bit_c, res_sr[BIT_WIDTH-1:1]};
        bus.borrow_out <= br_next_c;
        bus.overflow   <= ovf_c;
      end
    end
  end

endmodule

// File: doc/serial_sub_8bit.md
SERIAL_SUB_8BIT -- requirements
Module: serial_sub_8bit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, operand/result width; all values below assume 8.
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new subtraction; sampled on rising clk.
REQ-005 SHALL have port: a  input  8  minuend; captured with accepted start.
REQ-006 SHALL have port: b  input  8  subtrahend; captured with accepted start.
REQ-007 SHALL have port: borrow_in  input  1  incoming borrow; captured with accepted start.
REQ-008 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: diff  output  8  a - b - borrow_in, modulo 2^8.
REQ-011 SHALL have port: borrow_out  output  1  unsigned underflow: a < b + borrow_in.
REQ-012 SHALL have port: overflow  output  1  two's-complement overflow of the subtraction.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; accepted start latches a, b, borrow_in, clears bit counter and result shift register, enters CALC.
REQ-015 start asserted in CALC SHALL be ignored; latched operands and progress unaffected.
REQ-016 CALC SHALL process one bit per clk, LSB first: d_i = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br), br initialised from borrow_in.
REQ-017 3-bit counter SHALL count 0..7 in CALC; on the edge processing bit 7, FSM SHALL enter DONE.
REQ-018 Latency: start sampled at edge k -> done high during cycle after edge k+8 (8 CALC cycles).
REQ-019 busy SHALL be high exactly while state is CALC.
REQ-020 done SHALL be high exactly while state is DONE (one cycle), then FSM SHALL return to IDLE unless start accepted in DONE.
REQ-021 diff, borrow_out, overflow SHALL update only on entry to DONE and hold until the next entry to DONE; they SHALL NOT show partial results during CALC.
REQ-022 borrow_out SHALL equal final serial borrow after bit 7.
REQ-023 overflow SHALL equal (a[7] != b[7]) & (diff[7] != a[7]); borrow_in does not alter this rule beyond its effect on diff.
REQ-024 Input changes on a, b, borrow_in after acceptance SHALL not affect the in-flight result.

Reset
REQ-025 n_rst low SHALL asynchronously force state IDLE, counter 0, busy 0, done 0, diff 0x00, borrow_out 0, overflow 0, internal operand registers 0.
REQ-026 Reset during CALC SHALL abort the operation with no done pulse; first start after reset release SHALL behave as from power-up.

Verification
REQ-027 a=0x05, b=0x03, borrow_in=0, start 1 cycle -> busy 8 cycles, done pulse, diff=0x02, borrow_out=0, overflow=0.
REQ-028 a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1, overflow=0; a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0, overflow=0.
REQ-029 a=0x80, b=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
REQ-030 start re-pulsed with a=0xAA, b=0x55 mid-CALC of 0x05-0x03 -> ignored; done after original 8 cycles with diff=0x02.
REQ-031 n_rst pulsed low at CALC cycle 4 -> all outputs 0 immediately, no done; next start 0x09-0x04 -> diff=0x05 after 8 cycles.
REQ-032 start held high continuously with fixed operands -> back-to-back ops, done every 9th cycle, results identical each time.
